// File: rtl/execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : execute_stage
//  Description : EX stage of the 64-bit ARMv8-subset pipeline: ALU, zero flag,
//                branch target/decision, and the EX/MEM pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_stage #(
   parameter int DATA_W  = 64,
   parameter int SHAMT_W = 6
) (
   input  logic              clk,
   input  logic              resetl,
   input  logic              flush,
   input  logic              RegWrite_EX,
   input  logic              ALUSrc_EX,
   input  logic              Branch_EX,
   input  logic              Uncondbranch_EX,
   input  logic              MemRead_EX,
   input  logic              MemWrite_EX,
   input  logic              Mem2Reg_EX,
   input  logic [3:0]        ALUOp_EX,
   input  logic [4:0]        RD_EX,
   input  logic [DATA_W-1:0] RegOutA_EX,
   input  logic [DATA_W-1:0] RegOutB_EX,
   input  logic [DATA_W-1:0] SignExtImm64_EX,
   input  logic [DATA_W-1:0] pc_EX,
   output logic              RegWrite_MEM,
   output logic              MemRead_MEM,
   output logic              MemWrite_MEM,
   output logic              Mem2Reg_MEM,
   output logic              PCSrc_MEM,
   output logic              Zero_MEM,
   output logic [4:0]        RD_MEM,
   output logic [DATA_W-1:0] ALUResult_MEM,
   output logic [DATA_W-1:0] WriteData_MEM,
   output logic [DATA_W-1:0] BranchTarget_MEM
);

   localparam logic [3:0] c_ALU_AND  = 4'b0000;
   localparam logic [3:0] c_ALU_OR   = 4'b0001;
   localparam logic [3:0] c_ALU_ADD  = 4'b0010;
   localparam logic [3:0] c_ALU_XOR  = 4'b0011;
   localparam logic [3:0] c_ALU_SLL  = 4'b0100;
   localparam logic [3:0] c_ALU_SRL  = 4'b0101;
   localparam logic [3:0] c_ALU_SUB  = 4'b0110;
   localparam logic [3:0] c_ALU_PASS = 4'b0111;

   logic [DATA_W-1:0]  w_alu_b;
   logic [SHAMT_W-1:0] w_shamt;
   logic [DATA_W-1:0]  w_alu_result;
   logic               w_zero;
   logic [DATA_W-1:0]  w_branch_target;
   logic               w_pcsrc;

   assign w_alu_b = ALUSrc_EX ? SignExtImm64_EX : RegOutB_EX;
   assign w_shamt = w_alu_b[SHAMT_W-1:0];

   always_comb begin
      w_alu_result = '0;
      case (ALUOp_EX)
         c_ALU_AND:  w_alu_result = RegOutA_EX & w_alu_b;
         c_ALU_OR:   w_alu_result = RegOutA_EX | w_alu_b;
         c_ALU_ADD:  w_alu_result = RegOutA_EX + w_alu_b;
         c_ALU_XOR:  w_alu_result = RegOutA_EX ^ w_alu_b;
         c_ALU_SLL:  w_alu_result = RegOutA_EX << w_shamt;
         c_ALU_SRL:  w_alu_result = RegOutA_EX >> w_shamt;
         c_ALU_SUB:  w_alu_result = RegOutA_EX - w_alu_b;
         c_ALU_PASS: w_alu_result = w_alu_b;
         default:    w_alu_result = '0;
      endcase
   end

   assign w_zero          = (w_alu_result == '0);
   assign w_branch_target = pc_EX + (SignExtImm64_EX << 2);
   // Unconditional wins regardless of the CBZ condition
   assign w_pcsrc         = Uncondbranch_EX | (Branch_EX & w_zero);

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         RegWrite_MEM     <= 1'b0;
         MemRead_MEM      <= 1'b0;
         MemWrite_MEM     <= 1'b0;
         Mem2Reg_MEM      <= 1'b0;
         PCSrc_MEM        <= 1'b0;
         Zero_MEM         <= 1'b0;
         RD_MEM           <= '0;
         ALUResult_MEM    <= '0;
         WriteData_MEM    <= '0;
         BranchTarget_MEM <= '0;
      end else begin
         // A bubble only needs its side-effecting controls cleared
         RegWrite_MEM     <= RegWrite_EX & ~flush;
         MemRead_MEM      <= MemRead_EX  & ~flush;
         MemWrite_MEM     <= MemWrite_EX & ~flush;
         Mem2Reg_MEM      <= Mem2Reg_EX  & ~flush;
         PCSrc_MEM        <= w_pcsrc     & ~flush;
         Zero_MEM         <= w_zero;
         RD_MEM           <= RD_EX;
         ALUResult_MEM    <= w_alu_result;
         WriteData_MEM    <= RegOutB_EX;
         BranchTarget_MEM <= w_branch_target;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_execute_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_stage
//  Description : Directed-vector self-checking bench for execute_stage.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        resetl;
   logic        flush;
   logic        RegWrite_EX, ALUSrc_EX, Branch_EX, Uncondbranch_EX;
   logic        MemRead_EX, MemWrite_EX, Mem2Reg_EX;
   logic [3:0]  ALUOp_EX;
   logic [4:0]  RD_EX;
   logic [63:0] RegOutA_EX, RegOutB_EX, SignExtImm64_EX, pc_EX;
   logic        RegWrite_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM;
   logic        PCSrc_MEM, Zero_MEM;
   logic [4:0]  RD_MEM;
   logic [63:0] ALUResult_MEM, WriteData_MEM, BranchTarget_MEM;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   execute_stage #(.DATA_W(64), .SHAMT_W(6)) dut (
      .clk(clk), .resetl(resetl), .flush(flush),
      .RegWrite_EX(RegWrite_EX), .ALUSrc_EX(ALUSrc_EX), .Branch_EX(Branch_EX),
      .Uncondbranch_EX(Uncondbranch_EX), .MemRead_EX(MemRead_EX),
      .MemWrite_EX(MemWrite_EX), .Mem2Reg_EX(Mem2Reg_EX), .ALUOp_EX(ALUOp_EX),
      .RD_EX(RD_EX), .RegOutA_EX(RegOutA_EX), .RegOutB_EX(RegOutB_EX),
      .SignExtImm64_EX(SignExtImm64_EX), .pc_EX(pc_EX),
      .RegWrite_MEM(RegWrite_MEM), .MemRead_MEM(MemRead_MEM),
      .MemWrite_MEM(MemWrite_MEM), .Mem2Reg_MEM(Mem2Reg_MEM),
      .PCSrc_MEM(PCSrc_MEM), .Zero_MEM(Zero_MEM), .RD_MEM(RD_MEM),
      .ALUResult_MEM(ALUResult_MEM), .WriteData_MEM(WriteData_MEM),
      .BranchTarget_MEM(BranchTarget_MEM)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // {RegWrite, MemRead, MemWrite, Mem2Reg, PCSrc, Zero, RD}
   function automatic logic [63:0] ctl_word();
      return {53'd0, RegWrite_MEM, MemRead_MEM, MemWrite_MEM, Mem2Reg_MEM,
              PCSrc_MEM, Zero_MEM, RD_MEM};
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, ctl_word(), 64'd0);
      check({tag, "_alu"}, ALUResult_MEM, 64'd0);
      check({tag, "_wd"},  WriteData_MEM, 64'd0);
      check({tag, "_bt"},  BranchTarget_MEM, 64'd0);
   endtask

   task automatic idle();
      flush = 0; RegWrite_EX = 0; ALUSrc_EX = 0; Branch_EX = 0;
      Uncondbranch_EX = 0; MemRead_EX = 0; MemWrite_EX = 0; Mem2Reg_EX = 0;
      ALUOp_EX = 4'b0000; RD_EX = 5'd0; RegOutA_EX = 0; RegOutB_EX = 0;
      SignExtImm64_EX = 0; pc_EX = 0;
   endtask

   // Drive an ALU op, clock it through, and check result and zero flag
   task automatic alu_vec(input string tag, input logic [3:0] op, input logic src,
                          input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                          input logic [63:0] exp);
      @(negedge clk);
      idle();
      ALUOp_EX = op; ALUSrc_EX = src; RegOutA_EX = a; RegOutB_EX = b; SignExtImm64_EX = imm;
      @(posedge clk); #1;
      check({tag, "_res"}, ALUResult_MEM, exp);
      check({tag, "_zero"}, {63'd0, Zero_MEM}, {63'd0, exp == 64'd0});
   endtask

   initial begin
      // Reset held with random inputs
      resetl = 0;
      flush = $urandom; RegWrite_EX = 1; ALUSrc_EX = $urandom; Branch_EX = 1;
      Uncondbranch_EX = 1; MemRead_EX = 1; MemWrite_EX = 1; Mem2Reg_EX = 1;
      ALUOp_EX = 4'($urandom); RD_EX = 5'($urandom);
      RegOutA_EX = {$urandom, $urandom}; RegOutB_EX = {$urandom, $urandom} | 64'd1;
      SignExtImm64_EX = {$urandom, $urandom}; pc_EX = {$urandom, $urandom};
      repeat (3) @(posedge clk);
      #1 check_all_zero("rst_hold");

      // Release mid-cycle with an ADD-immediate pending
      @(negedge clk);
      idle();
      RegOutA_EX = 64'd10; SignExtImm64_EX = 64'd5; ALUSrc_EX = 1;
      ALUOp_EX = 4'b0010; RD_EX = 5'd3; RegWrite_EX = 1;
      resetl = 1;
      #1 check_all_zero("rst_release");
      @(posedge clk); #1;
      check("addi_res", ALUResult_MEM, 64'd15);
      check("addi_ctl", ctl_word(), {53'd0, 1'b1, 4'b0000, 1'b0, 5'd3});

      // SUB wrap and SUB to zero
      alu_vec("sub_wrap", 4'b0110, 0, 64'd0, 64'd1, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
      alu_vec("sub_zero", 4'b0110, 0, 64'h1234, 64'h1234, 64'd0, 64'd0);

      // Logic ops, pass-B and undefined opcode
      alu_vec("and", 4'b0000, 0, 64'hF0F0_0000_FFFF_1234, 64'h0FF0_FFFF_00FF_00FF, 0, 64'h00F0_0000_00FF_0034);
      alu_vec("or",  4'b0001, 0, 64'hF000_0000_0000_0001, 64'h000F_0000_0000_0010, 0, 64'hF00F_0000_0000_0011);
      alu_vec("xor", 4'b0011, 1, 64'hAAAA_AAAA_AAAA_AAAA, 64'd0, 64'hFFFF_0000_FFFF_0000, 64'h5555_AAAA_5555_AAAA);
      alu_vec("pass", 4'b0111, 1, 64'd99, 64'd7, 64'h42, 64'h42);
      alu_vec("undef", 4'b1000, 0, 64'd5, 64'd6, 64'd0, 64'd0);

      // Shifts, including shift amount 64 wrapping to 0
      alu_vec("sll63", 4'b0100, 1, 64'd1, 64'd0, 64'd63, 64'h8000_0000_0000_0000);
      alu_vec("srl63", 4'b0101, 1, 64'h8000_0000_0000_0000, 64'd0, 64'd63, 64'd1);
      alu_vec("sll64", 4'b0100, 0, 64'h5A, 64'h40, 64'd0, 64'h5A);
      alu_vec("srl64", 4'b0101, 0, 64'h5A, 64'h40, 64'd0, 64'h5A);

      // CBZ taken
      @(negedge clk); idle();
      Branch_EX = 1; ALUOp_EX = 4'b0111; RegOutB_EX = 0; pc_EX = 64'h100; SignExtImm64_EX = 64'd4;
      @(posedge clk); #1;
      check("cbz_taken", {63'd0, PCSrc_MEM}, 64'd1);
      check("cbz_target", BranchTarget_MEM, 64'h110);
      // CBZ not taken
      @(negedge clk); RegOutB_EX = 64'd7;
      @(posedge clk); #1;
      check("cbz_not", {63'd0, PCSrc_MEM}, 64'd0);
      // Negative offset
      @(negedge clk); RegOutB_EX = 64'd0; SignExtImm64_EX = 64'hFFFF_FFFF_FFFF_FFFE;
      @(posedge clk); #1;
      check("cbz_neg_target", BranchTarget_MEM, 64'hF8);
      check("cbz_neg_taken", {63'd0, PCSrc_MEM}, 64'd1);
      // Both branch flags with nonzero operand: unconditional wins
      @(negedge clk); RegOutB_EX = 64'd7; Uncondbranch_EX = 1;
      @(posedge clk); #1;
      check("both_br", {63'd0, PCSrc_MEM}, 64'd1);

      // Flushed store with a pending unconditional branch
      @(negedge clk); idle();
      MemWrite_EX = 1; RegOutB_EX = 64'hDEAD; Uncondbranch_EX = 1; RegWrite_EX = 1;
      MemRead_EX = 1; Mem2Reg_EX = 1; flush = 1; RD_EX = 5'd9;
      ALUOp_EX = 4'b0010; RegOutA_EX = 64'd1; RegOutB_EX = 64'hDEAD;
      @(posedge clk); #1;
      check("flush_ctl", ctl_word() & 64'h7C0, 64'd0);
      check("flush_wd", WriteData_MEM, 64'hDEAD);
      check("flush_rd", {59'd0, RD_MEM}, 64'd9);
      check("flush_alu", ALUResult_MEM, 64'hDEAE);
      @(negedge clk); flush = 0;
      @(posedge clk); #1;
      check("unflush_ctl", ctl_word() & 64'h7C0, 64'h7C0);

      // Asynchronous reset pulse between edges
      @(negedge clk);
      resetl = 0;
      #1 check_all_zero("rst_pulse");
      #2 resetl = 1;
      #1 check_all_zero("rst_after_pulse");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
